// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, register map constants and baud helper.
package uart_pkg;
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;
  localparam logic [31:0] UART_TX_ADDR   = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
  localparam int RX_VALID = 0;
  localparam int TX_BUSY  = 1;
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, extra pointer bit distinguishes full from empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wr_q == rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  // pointer update; full/empty are sampled before this edge's push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  // storage needs no reset, only the pointers define validity
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic       tx_overflow,
  output logic       txd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, head;
  logic          txd_q, txd_d, ovf_q, full, empty, wrap, load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (tx_we),
    .pop_i  (load),
    .wdata_i(tx_data),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  assign wrap = baud_q == BW'(CLKS_PER_BIT - 1);
  assign load = !empty && (state_q == ST_IDLE || (state_q == ST_STOP && wrap));

  // frame sequencing; a pop on the last stop cycle chains frames with no idle gap
  always_comb begin
    state_d = state_q;
    baud_d  = (wrap || load || state_q == ST_IDLE) ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    if (load) begin
      state_d = ST_START;
      shift_d = head;
      bit_d   = '0;
    end else if (wrap) begin
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_q == 3'd7) state_d = ST_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  assign par_d = load ? ^head : par_q;
  assign txd_d = state_d == ST_START  ? 1'b0 :
                 state_d == ST_DATA   ? shift_d[0] :
                 state_d == ST_PARITY ? par_d : 1'b1;
`else
  assign txd_d = state_d == ST_START ? 1'b0 :
                 state_d == ST_DATA  ? shift_d[0] : 1'b1;
`endif

  // state registers; reset abandons any frame and forces the line high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= tx_we && full;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd         = txd_q;
  assign tx_overflow = ovf_q;
  assign tx_busy     = full;
  assign tx_idle     = state_q == ST_IDLE && empty;
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmit peripheral on the far side of the CPU's memory-mapped TX port (store to 0x1000_0000). It accepts bytes on a one-cycle write strobe, buffers them in a small FIFO, and serialises them 8N1, LSB first, on `txd`. It reports `tx_busy` back to the CPU status word (bit 1 of 0x1000_0004), so firmware can poll before writing.

Parameters:
- CLK_FREQ, default 100000000: system clock frequency in Hz.
- BAUD, default 115200: line rate in bit/s.
- CLKS_PER_BIT, default CLK_FREQ/BAUD (truncating integer division, 868): clocks per serial bit. Must be ≥ 2.
- FIFO_DEPTH, default 4: TX buffer entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active low.
- tx_data  in  8  byte to send; sampled when tx_we = 1.
- tx_we  in  1  single-cycle write strobe from the CPU store path.
- tx_busy  out  1  FIFO full; writes are not accepted while high.
- tx_idle  out  1  FIFO empty and FSM in IDLE (line fully drained).
- tx_overflow  out  1  one-cycle pulse when a write is dropped.
- txd  out  1  serial line output; idles high.

Behaviour:
- Reset (rst = 0, asynchronous):
  - txd = 1, tx_busy = 0, tx_idle = 1, tx_overflow = 0.
  - FIFO emptied, FSM to IDLE, bit and baud counters cleared.
  - A frame in flight is abandoned and never resumed.
- All outputs are registered.
- FIFO push:
  - On edge k with tx_we = 1 and not full, tx_data is pushed.
  - With tx_we = 1 and full, the byte is dropped and tx_overflow = 1 for the cycle after edge k.
  - Full is evaluated before any pop on the same edge; a pop on that edge does not make room for the push.
- tx_busy: high exactly while FIFO count == FIFO_DEPTH; updates the cycle after the push or pop edge.
- FSM states: IDLE → START → DATA → STOP → (START | IDLE).
  - IDLE: txd = 1. If the FIFO is non-empty at an edge, pop the head into the shift register, clear the counters, go to START.
  - START: txd = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, shift register bit 0 first, each held CLKS_PER_BIT cycles; bit index counts 0..7.
  - STOP: txd = 1 for CLKS_PER_BIT cycles. On its last cycle:
    - FIFO non-empty: pop and go directly to START (zero idle gap between frames).
    - FIFO empty: go to IDLE.
- Latency: a write at edge k into an empty FIFO with the FSM in IDLE drives txd low after edge k+1.
- Frame length: exactly 10 × CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT−1 and wraps; the bit advances on the wrap.
- tx_idle: low from the cycle after the push edge until the cycle after the final STOP cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP transmits an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11 × CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding typedef (IDLE, START, DATA, PARITY, STOP).
  - UART_TX_ADDR = 32'h1000_0000 and UART_STAT_ADDR = 32'h1000_0004.
  - Status bit indices: RX_VALID = 0, TX_BUSY = 1.
  - Default-computation helper for CLKS_PER_BIT.
- One sub-module, uart_tx_fifo: synchronous FIFO with pointer wrap and extra-bit full/empty detection, parameterised by depth and width, same clk/rst.

Test Plan (CLK_FREQ = 16, BAUD = 1, so CLKS_PER_BIT = 16; FIFO_DEPTH = 4):
1. Release reset, idle 50 cycles → txd = 1, tx_busy = 0, tx_idle = 1, tx_overflow never pulses.
2. Write 0x55 at edge k → txd = 0 over cycles k+1..k+16, then 1,0,1,0,1,0,1,0 for 16 cycles each, then stop = 1 for 16 cycles; tx_idle = 1 after cycle k+160.
3. Write 0x01..0x06 on six consecutive edges k..k+5:
   - tx_busy = 1 after edge k+4.
   - 0x06 is dropped, with tx_overflow pulsing once after edge k+5.
   - Bytes 0x01..0x05 leave back-to-back with no idle cycles between stop and start bits; 800 cycles total.
4. With the FIFO full, assert tx_we on the same edge as a STOP→START pop → write dropped, tx_overflow pulses, count becomes 3, tx_busy falls.
5. Assert rst = 0 during DATA bit 3 of 0xA5 with 2 bytes queued → txd = 1 immediately (asynchronous); after release, tx_idle = 1 and nothing is transmitted.
6. With UART_TX_PARITY_EN, write 0x07 → data bits 1,1,1,0,0,0,0,0, parity bit = 1, stop = 1; frame is 176 cycles.
